// File: rtl/muldiv_ctrl.sv
// Multicycle MULT/MULTU/DIV/DIVU controller.
// Takes one request from the execute stage and runs a 32-step iterative core.
// A multiply uses shift-add. A divide uses restoring division.
// The HI/LO write pair is presented for one cycle when the result is ready.
//
// Handshake: a request transfers on a rising edge where
// req_valid && req_ready && !flush. req_ready is high only while idle.
// The requester may change req_* freely after the transfer edge because the
// operands are captured at that edge. done, hi_wr.valid and lo_wr.valid
// form a single-cycle strobe with no back-pressure.

package muldiv_pkg;
    typedef logic [31:0] word_t;
    typedef logic [63:0] dword_t;

    typedef enum logic [1:0] {
        M_MULT  = 2'd0,
        M_MULTU = 2'd1,
        M_DIV   = 2'd2,
        M_DIVU  = 2'd3
    } multicycle_t;

    typedef struct packed {
        logic  valid;
        word_t data;
    } hilo_write_req;
endpackage

module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    input  multicycle_t   req_op,
    input  word_t         req_a,
    input  word_t         req_b,
    output logic          req_ready,
    output logic          busy,
    input  logic          flush,
    output logic          done,
    output hilo_write_req hi_wr,
    output hilo_write_req lo_wr,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] cnt;
    dword_t     acc;      // mult: {partial hi, multiplier/low}; div: {remainder, dividend/quotient}
    word_t      opnd;     // multiplicand magnitude (mult) or divisor magnitude (div)
    word_t      a_orig;   // original dividend, returned as HI on divide by zero
    logic       div_q;
    logic       neg_lo;   // negate product (mult) or quotient (div)
    logic       neg_hi;   // negate remainder (div)
    logic       div0;

    // Operand magnitudes and sign bookkeeping at the accept edge
    logic  req_signed;
    logic  req_div;
    word_t abs_a;
    word_t abs_b;

    always_comb begin
        req_signed = (req_op == M_MULT) || (req_op == M_DIV);
        req_div    = (req_op == M_DIV)  || (req_op == M_DIVU);
        abs_a      = (req_signed && req_a[31]) ? (32'd0 - req_a) : req_a;
        abs_b      = (req_signed && req_b[31]) ? (32'd0 - req_b) : req_b;
    end

    // One iteration step of each datapath, selected by the latched op class
    logic [32:0] mul_sum;
    dword_t      mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    word_t       div_diff;
    word_t       div_rem;
    dword_t      div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        mul_next  = {mul_sum, acc[31:1]};
        div_shift = {acc[63:32], acc[31]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[31:0] - opnd;
        div_rem   = div_ge ? div_diff : div_shift[31:0];
        div_next  = {div_rem, acc[30:0], div_ge};
    end

    // Sign fix-up and special cases applied to the finished accumulator
    dword_t prod;
    word_t  quo;
    word_t  rem;
    word_t  res_hi;
    word_t  res_lo;

    always_comb begin
        prod = neg_lo ? (64'd0 - acc) : acc;
        quo  = neg_lo ? (32'd0 - acc[31:0]) : acc[31:0];
        rem  = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
        if (!div_q) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (div0) begin
            res_hi = a_orig;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // Control FSM: accept, 32 iterations, one result cycle; flush aborts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            a_orig <= 32'd0;
            div_q  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        state  <= S_RUN;
                        cnt    <= 6'd0;
                        div_q  <= req_div;
                        a_orig <= req_a;
                        div0   <= (req_b == 32'd0);
                        opnd   <= req_div ? abs_b : abs_a;
                        acc    <= {32'd0, (req_div ? abs_a : abs_b)};
                        neg_lo <= req_signed && (req_a[31] ^ req_b[31]);
                        neg_hi <= req_signed && req_div && req_a[31];
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                        cnt   <= 6'd0;
                        acc   <= 64'd0;
                    end else begin
                        acc <= div_q ? div_next : mul_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= 6'd0;
                    acc   <= 64'd0;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end

    // Status and result strobes; a flush in the result cycle suppresses the write
    always_comb begin
        req_ready     = (state == S_IDLE);
        busy          = (state == S_RUN) || (state == S_DONE);
        done          = (state == S_DONE) && !flush;
        hi_wr.valid   = done;
        hi_wr.data    = done ? res_hi : 32'd0;
        lo_wr.valid   = done;
        lo_wr.data    = done ? res_lo : 32'd0;
        state_dbg     = state;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed MIPS mul/div cases, random
// operations against a plain-arithmetic reference, flush/reset aborts and
// back-to-back issue timing.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    multicycle_t   req_op = M_MULT;
    word_t         req_a = 32'd0;
    word_t         req_b = 32'd0;
    logic          flush = 1'b0;
    logic          req_ready;
    logic          busy;
    logic          done;
    hilo_write_req hi_wr;
    hilo_write_req lo_wr;
    logic [1:0]    state_dbg;

    int n_assert = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    muldiv_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .busy      (busy),
        .flush     (flush),
        .done      (done),
        .hi_wr     (hi_wr),
        .lo_wr     (lo_wr),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {HI, LO} straight from MIPS arithmetic rules
    function automatic logic [63:0] model(input multicycle_t op, input word_t a, input word_t b);
        longint sa;
        longint sb;
        int     ia;
        int     ib;
        int     q;
        int     r;
        logic [63:0] p;
        case (op)
            M_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            M_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = sa * sb;
                return p;
            end
            M_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ia = $signed(a);
                ib = $signed(b);
                q = ia / ib;
                r = ia % ib;
                return {word_t'(r), word_t'(q)};
            end
        endcase
    endfunction

    // Driver: present a request (called at a negedge) and return just after the accept edge
    task automatic issue(input multicycle_t op, input word_t a, input word_t b, output int waits);
        logic rdy;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        exp_q.push_back(model(op, a, b));
        waits = 0;
        for (int i = 0; i < 8; i++) begin
            rdy = req_ready && !flush;
            @(posedge clk);
            if (rdy) return;
            waits++;
            @(negedge clk);
        end
        n_assert++;
        n_fail++;
        $error("FAIL accept_timeout: observed no accept expected accept within 8 cycles");
    endtask

    // Wait for done, counting negedges after accept; optionally scramble inputs after accept
    task automatic wait_done(input bit drop, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (drop && k == 1) begin
                req_valid = 1'b0;
                req_op = multicycle_t'($urandom_range(0, 3));
                req_a = $urandom;
                req_b = $urandom;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                return;
            end
        end
    endtask

    // Scoreboard: compare the strobed HI/LO pair against the queued expectation
    task automatic check_result(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_queue: observed empty expected one entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_hi"}, hi_wr.data, e[63:32]);
        check({tag, "_lo"}, lo_wr.data, e[31:0]);
        check({tag, "_valid"}, {hi_wr.valid, lo_wr.valid}, 2'b11);
    endtask

    task automatic finish_op(input string tag, input bit drop);
        int lat;
        bit bok;
        wait_done(drop, lat, bok);
        check({tag, "_lat"}, lat, 33);
        check({tag, "_busy"}, bok, 1);
        if (lat != 0) check_result(tag);
        else if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic run_op(input string tag, input multicycle_t op, input word_t a, input word_t b);
        int w;
        issue(op, a, b, w);
        finish_op(tag, 1'b1);
    endtask

    initial begin
        int w;
        int lat;
        int dcnt;
        bit bok;
        multicycle_t rop;
        word_t ra;
        word_t rb;

        // Reset state
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi_wr", hi_wr, 0);
        check("rst_lo_wr", lo_wr, 0);
        check("rst_state", state_dbg, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op("multu_max", M_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", M_MULT, 32'hFFFF_FFFE, 32'd3);
        run_op("div_neg", M_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", M_DIVU, 32'd100, 32'd7);
        run_op("divu_by0", M_DIVU, 32'd5, 32'd0);
        run_op("div_ovf", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_by0", M_DIV, 32'hFFFF_FFFB, 32'd0);
        run_op("mult_min", M_MULT, 32'h8000_0000, 32'h8000_0000);
        run_op("div_min", M_DIV, 32'h8000_0000, 32'd7);

        // Random operations
        for (int i = 0; i < 12; i++) begin
            rop = multicycle_t'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : word_t'($urandom);
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 28);
            run_op("rand", rop, ra, rb);
        end

        // Flush during RUN
        issue(M_DIVU, $urandom, $urandom, w);
        void'(exp_q.pop_back());
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_ready", req_ready, 1);
        check("flush_run_busy", busy, 0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("flush_run_nodone", dcnt, 0);
        run_op("after_flush", M_DIVU, 32'd9, 32'd3);

        // Flush during DONE
        issue(M_MULTU, $urandom, $urandom, w);
        void'(exp_q.pop_back());
        wait_done(1'b1, lat, bok);
        check("flush_done_lat", lat, 33);
        flush = 1'b1;
        #1;
        check("flush_done_done", done, 0);
        check("flush_done_hi", hi_wr, 0);
        check("flush_done_lo", lo_wr, 0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_ready", req_ready, 1);

        // req_valid and flush collide in IDLE
        req_valid = 1'b1;
        req_op = M_DIVU;
        req_a = 32'd50;
        req_b = 32'd5;
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("collide_busy", busy, 0);
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check("collide_ready", req_ready, 1);

        // Back-to-back with req_valid held high
        issue(M_MULT, $urandom, $urandom, w);
        finish_op("b2b_first", 1'b0);
        issue(M_DIVU, $urandom, $urandom_range(1, 1000), w);
        check("b2b_gap", w, 1);
        finish_op("b2b_second", 1'b1);

        // Reset mid-RUN
        issue(M_MULTU, $urandom, $urandom, w);
        void'(exp_q.pop_back());
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("rstrun_ready", req_ready, 1);
        check("rstrun_busy", busy, 0);
        check("rstrun_done", done, 0);
        check("rstrun_hi_wr", hi_wr, 0);
        check("rstrun_lo_wr", lo_wr, 0);
        check("rstrun_state", state_dbg, 0);
        @(negedge clk);
        resetn = 1'b1;
        issue(M_DIV, 32'hFFFF_FF9C, 32'd7, w);
        check("rstrun_first_edge", w, 0);
        #1;
        check("rstrun_accept_busy", busy, 1);
        finish_op("after_rst", 1'b1);

        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
